mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  - Shares one multiplier (A/B/i_valid/ready in, P/o_valid out) among NREQ requesters.
//  - Round-robin arbitration; exactly one operation in flight at a time.
//  - The result is routed back to the requester that issued the operation.
//  - Sits between testbench/system requesters and the multiplier DUT port.
// PARAMETERS
//  WIDTH    4   operand width; product width is 2*WIDTH
//  NREQ     3   number of requesters, >=2
//  TIMEOUT  64  WAIT-state cycle limit, used only with MULT_ARB_TIMEOUT_EN; >=2
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  req_valid  in   NREQ         per-requester operation request
//  req_a      in   NREQ*WIDTH   operand A; slice i belongs to requester i
//  req_b      in   NREQ*WIDTH   operand B; slice i belongs to requester i
//  req_ready  out  NREQ         one-hot 1-cycle accept pulse
//  rsp_valid  out  NREQ         one-hot 1-cycle result pulse
//  rsp_p      out  2*WIDTH      shared result bus; valid while any rsp_valid bit is set
//  rsp_err    out  1            timeout flag, qualified by rsp_valid
//  m_a        out  WIDTH        operand A to multiplier
//  m_b        out  WIDTH        operand B to multiplier
//  m_i_valid  out  1            operation valid to multiplier
//  m_ready    in   1            multiplier can accept an operation
//  m_p        in   2*WIDTH      product from multiplier
//  m_o_valid  in   1            product valid
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: every output is 0, state=IDLE, rr_ptr=0, owner=0.
//  - FSM IDLE->ISSUE->WAIT->RESP->IDLE.
//  - IDLE, any req_valid set:
//      grant = first set bit searching rr_ptr, rr_ptr+1, ... wrapping mod NREQ.
//      req_ready[grant]=1 next cycle; A/B latched into m_a/m_b; owner=grant; go ISSUE.
//  - A request is consumed on the req_ready pulse; the requester drops or updates req_valid after it.
//  - ISSUE:
//      m_i_valid=1; m_a/m_b held stable.
//      On m_i_valid&m_ready, go WAIT and clear m_i_valid next cycle.
//  - WAIT: on m_o_valid, latch m_p into rsp_p; go RESP.
//  - RESP:
//      rsp_valid[owner]=1 for exactly one cycle; rsp_err as set.
//      rr_ptr=(owner+1) mod NREQ; go IDLE.
//  - No response backpressure.
//  - m_o_valid outside WAIT is ignored (stale or spurious).
//  - The multiplier latency is >=1 cycle after its accept handshake.
//  - Minimum issue-to-issue interval: 4 cycles plus multiplier latency.
//  - rsp_p holds its last value when rsp_valid=0.
//  - Products use full 2*WIDTH width; no truncation; unsigned.
//  - Reset mid-operation:
//      Immediate return to IDLE; all outputs 0.
//      The in-flight result is dropped; no rsp_valid is issued for it.
//  - Requests arriving during ISSUE/WAIT/RESP wait; they are never dropped.
// CONFIGURATION
//  - MULT_ARB_TIMEOUT_EN defined:
//      A counter runs in WAIT. After TIMEOUT cycles with no m_o_valid, go RESP with rsp_err=1, rsp_p=0.
//      A late m_o_valid is then ignored.
//  - MULT_ARB_TIMEOUT_EN undefined:
//      No counter; WAIT lasts indefinitely.
//      The rsp_err port still exists and is tied 0.
// STRUCTURE
//  - mult_arb_pkg holds:
//      state_e enum {IDLE, ISSUE, WAIT, RESP};
//      a localparam helper for the id width, $clog2(NREQ);
//      the default TIMEOUT constant.
//  - Sub-module mult_rr_pick: combinational rotate-priority pick (req vector, ptr -> grant id, any).
//    Instantiated once.
// TESTING (WIDTH=4, NREQ=3, TIMEOUT=8, multiplier latency 2)
//  - Req1 only, A=3, B=5 -> one req_ready[1] pulse; m_a=3, m_b=5; rsp_valid[1] with rsp_p=8'h0F.
//  - Req0..2 held from reset, A=i+1, B=2 -> grants in order 0,1,2,0.
//      rsp_p sequence 2,4,6,2.
//  - A=15, B=15 -> rsp_p=8'hE1; rsp_err=0.
//  - m_ready held low 10 cycles in ISSUE -> m_i_valid stays 1; m_a/m_b stable; no rsp until accept.
//  - rst_n low in WAIT, then m_o_valid arrives after release -> no rsp_valid; next request handled normally.
//  - Macro on, multiplier silent -> after 8 WAIT cycles rsp_valid[owner] with rsp_err=1, rsp_p=0.
//      Macro off: no response.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 64;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_rr_pick.sv
// Rotate-priority picker: first set request bit starting at ptr, wrapping mod NREQ.
module mult_rr_pick
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant,
    output logic            any
);

    // Walk the request vector from ptr onward and keep the first hit.
    always_comb begin
        logic [IDW-1:0] idx;
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IDW'((32'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters, one
// operation in flight. Optional WAIT-state timeout: MULT_ARB_TIMEOUT_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]      rsp_p,
    output logic                    rsp_err,
    output logic [WIDTH-1:0]        m_a,
    output logic [WIDTH-1:0]        m_b,
    output logic                    m_i_valid,
    input  logic                    m_ready,
    input  logic [2*WIDTH-1:0]      m_p,
    input  logic                    m_o_valid
);

    localparam int unsigned IDW = id_width(NREQ);

    if (NREQ < 2 || TIMEOUT < 2) begin : g_param_check
        $error("mult_arbiter: NREQ and TIMEOUT must both be at least 2");
    end

    state_e             state, state_n;
    logic [IDW-1:0]     rr_ptr, rr_ptr_n;
    logic [IDW-1:0]     owner, owner_n;
    logic [IDW-1:0]     pick_id;
    logic               pick_any;
    logic [NREQ-1:0]    req_ready_n, rsp_valid_n;
    logic [2*WIDTH-1:0] rsp_p_n;
    logic [WIDTH-1:0]   m_a_n, m_b_n;
    logic               m_i_valid_n;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT);
    logic [TW-1:0]      wait_cnt, wait_cnt_n;
    logic               rsp_err_n;
`endif

    mult_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_id),
        .any   (pick_any)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and next-output decode; every output is a registered copy.
    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        owner_n     = owner;
        req_ready_n = '0;
        rsp_valid_n = '0;
        rsp_p_n     = rsp_p;
        m_a_n       = m_a;
        m_b_n       = m_b;
        m_i_valid_n = m_i_valid;
`ifdef MULT_ARB_TIMEOUT_EN
        rsp_err_n   = 1'b0;
        wait_cnt_n  = '0;
`endif
        case (state)
            IDLE: begin
                if (pick_any) begin
                    req_ready_n[pick_id] = 1'b1;
                    m_a_n       = req_a[pick_id*WIDTH +: WIDTH];
                    m_b_n       = req_b[pick_id*WIDTH +: WIDTH];
                    owner_n     = pick_id;
                    m_i_valid_n = 1'b1;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                if (m_i_valid && m_ready) begin
                    m_i_valid_n = 1'b0;
                    state_n     = WAIT;
                end
            end
            WAIT: begin
                if (m_o_valid) begin
                    rsp_p_n            = m_p;
                    rsp_valid_n[owner] = 1'b1;
                    state_n            = RESP;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    rsp_p_n            = '0;
                    rsp_err_n          = 1'b1;
                    rsp_valid_n[owner] = 1'b1;
                    state_n            = RESP;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
`endif
            end
            RESP: begin
                rr_ptr_n = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            owner     <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_p     <= '0;
            m_a       <= '0;
            m_b       <= '0;
            m_i_valid <= 1'b0;
        end else begin
            rr_ptr    <= rr_ptr_n;
            owner     <= owner_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_p     <= rsp_p_n;
            m_a       <= m_a_n;
            m_b       <= m_b_n;
            m_i_valid <= m_i_valid_n;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    // WAIT-cycle counter and the timeout flag that accompanies rsp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_n;
            rsp_err  <= rsp_err_n;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a latency-configurable multiplier model.
module tb_mult_arbiter;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned NREQ    = 3;
    localparam int unsigned TIMEOUT = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]    rsp_p;
    logic                  rsp_err;
    logic [WIDTH-1:0]      m_a, m_b;
    logic                  m_i_valid;
    logic                  m_ready = 1'b1;
    logic [2*WIDTH-1:0]    m_p = '0;
    logic                  m_o_valid = 1'b0;

    always #5 clk = ~clk;

    mult_arbiter #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .rsp_err   (rsp_err),
        .m_a       (m_a),
        .m_b       (m_b),
        .m_i_valid (m_i_valid),
        .m_ready   (m_ready),
        .m_p       (m_p),
        .m_o_valid (m_o_valid)
    );

    typedef struct {
        int unsigned id;
        logic [7:0]  p;
        logic        err;
    } rsp_t;

    rsp_t        rsp_q[$];
    int unsigned grant_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned rsp_total = 0;

    // Requester state: operands, requests wanted, requests granted so far.
    logic [WIDTH-1:0] opa[NREQ];
    logic [WIDTH-1:0] opb[NREQ];
    int unsigned      target[NREQ];
    int unsigned      granted[NREQ];
    logic             exp_err = 1'b0;
    logic             no_rsp = 1'b0;

    // Multiplier model controls.
    int unsigned lat = 2;
    int unsigned stall_len = 0;
    logic        silent = 1'b0;
    int unsigned stall_cnt = 0;
    int unsigned mul_cnt = 0;
    logic [7:0]  mul_prod = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Multiplier: accepts on m_i_valid & m_ready, answers lat edges later.
    always @(negedge clk) begin
        m_o_valid = 1'b0;
        if (mul_cnt != 0) begin
            mul_cnt--;
            if (mul_cnt == 0 && !silent) begin
                m_o_valid = 1'b1;
                m_p       = mul_prod;
            end
        end
        if (m_i_valid) begin
            if (stall_cnt < stall_len) begin
                m_ready = 1'b0;
                stall_cnt++;
            end else begin
                m_ready = 1'b1;
            end
        end else begin
            m_ready   = 1'b1;
            stall_cnt = 0;
        end
        if (m_i_valid && m_ready) begin
            mul_cnt  = lat;
            mul_prod = 8'(m_a) * 8'(m_b);
        end
    end

    // Grant/response monitor plus requester drivers.
    always @(negedge clk) begin
        int unsigned g;
        rsp_t        e;
        rsp_t        n;
        if (req_ready != '0) begin
            if (grant_q.size() == 0) begin
                check("grant_unexpected", 32'(req_ready), 32'h0);
            end else begin
                g = grant_q.pop_front();
                check("grant", 32'(req_ready), 32'h1 << g);
                check("m_a", 32'(m_a), 32'(opa[g]));
                check("m_b", 32'(m_b), 32'(opb[g]));
                check("m_i_valid_at_grant", 32'(m_i_valid), 32'h1);
                if (!no_rsp) begin
                    n.id  = g;
                    n.p   = exp_err ? 8'h00 : 8'(opa[g]) * 8'(opb[g]);
                    n.err = exp_err;
                    rsp_q.push_back(n);
                end
            end
            for (int unsigned i = 0; i < NREQ; i++)
                if (req_ready[i]) granted[i]++;
        end
        if (rsp_valid != '0) begin
            rsp_total++;
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_id", 32'(rsp_valid), 32'h1 << e.id);
                check("rsp_p", 32'(rsp_p), 32'(e.p));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_valid[i]             = granted[i] < target[i];
            req_a[i*WIDTH +: WIDTH]  = opa[i];
            req_b[i*WIDTH +: WIDTH]  = opb[i];
        end
    end

    task automatic wait_rsp(input int unsigned n, input string tag);
        int unsigned k = 0;
        while (rsp_total < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, rsp_total, n);
    endtask

    task automatic wait_ready(input string tag);
        logic seen = 1'b0;
        for (int unsigned k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'h1);
    endtask

    task automatic wait_accept(input string tag);
        logic done = 1'b0;
        for (int unsigned k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (!m_i_valid) done = 1'b1;
        end
        check(tag, 32'(done), 32'h1);
    endtask

    task automatic issue(input int unsigned id, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int unsigned cnt);
        opa[id]    = a;
        opb[id]    = b;
        target[id] = target[id] + cnt;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_p"}, 32'(rsp_p), 32'h0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        check({tag, "_m_a"}, 32'(m_a), 32'h0);
        check({tag, "_m_b"}, 32'(m_b), 32'h0);
        check({tag, "_m_i_valid"}, 32'(m_i_valid), 32'h0);
    endtask

    initial begin
        int unsigned wc;
        for (int unsigned i = 0; i < NREQ; i++) begin
            opa[i] = '0; opb[i] = '0; target[i] = 0; granted[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // All three requesting from reset: grants 0,1,2,0 with products 2,4,6,2.
        @(posedge clk); #1;
        issue(0, 4'd1, 4'd2, 2);
        issue(1, 4'd2, 4'd2, 1);
        issue(2, 4'd3, 4'd2, 1);
        grant_q.push_back(0); grant_q.push_back(1);
        grant_q.push_back(2); grant_q.push_back(0);
        wait_rsp(4, "rr_sequence_done");

        // Single requester 1: 3*5 = 0x0F.
        @(posedge clk); #1;
        issue(1, 4'd3, 4'd5, 1);
        grant_q.push_back(1);
        wait_rsp(5, "req1_done");

        // Maximum operands on requester 2: 15*15 = 0xE1, then rsp_p must hold.
        @(posedge clk); #1;
        issue(2, 4'd15, 4'd15, 1);
        grant_q.push_back(2);
        wait_rsp(6, "max_done");
        repeat (3) @(negedge clk);
        check("rsp_p_hold", 32'(rsp_p), 32'hE1);
        check("rsp_valid_idle", 32'(rsp_valid), 32'h0);

        // Multiplier refuses for 10 ISSUE cycles: request stays presented.
        @(posedge clk); #1;
        stall_len = 10;
        issue(0, 4'd7, 4'd9, 1);
        grant_q.push_back(0);
        wait_ready("stall_ready_seen");
        for (int unsigned j = 0; j < 10; j++) begin
            check("stall_m_i_valid", 32'(m_i_valid), 32'h1);
            check("stall_m_a", 32'(m_a), 32'h7);
            check("stall_m_b", 32'(m_b), 32'h9);
            check("stall_no_rsp", 32'(rsp_valid), 32'h0);
            @(negedge clk);
        end
        wait_rsp(7, "stall_done");
        @(posedge clk); #1;
        stall_len = 0;

        // Reset while waiting: the late product must not produce a response.
        lat    = 6;
        no_rsp = 1'b1;
        issue(1, 4'd2, 4'd3, 1);
        grant_q.push_back(1);
        wait_ready("rst_ready_seen");
        wait_accept("rst_accept_seen");
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_rsp_after_reset", rsp_total, 7);
        @(posedge clk); #1;
        lat    = 2;
        no_rsp = 1'b0;
        issue(2, 4'd4, 4'd4, 1);
        grant_q.push_back(2);
        wait_rsp(8, "post_reset_done");

        // Silent multiplier.
        @(posedge clk); #1;
        silent = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
        exp_err = 1'b1;
        issue(0, 4'd1, 4'd1, 1);
        grant_q.push_back(0);
        wait_ready("to_ready_seen");
        wait_accept("to_accept_seen");
        wc = 1;
        while (rsp_valid == '0 && wc < 50) begin
            @(negedge clk);
            if (rsp_valid == '0) wc++;
        end
        check("timeout_wait_cycles", wc, TIMEOUT);
        wait_rsp(9, "timeout_done");
`else
        no_rsp = 1'b1;
        issue(0, 4'd1, 4'd1, 1);
        grant_q.push_back(0);
        wait_ready("silent_ready_seen");
        wc = 0;
        repeat (40) @(negedge clk);
        check("silent_no_rsp", rsp_total + wc, 8);
        check("silent_rsp_err", 32'(rsp_err), 32'h0);
`endif

        check("rsp_queue_empty", rsp_q.size(), 0);
        check("grant_queue_empty", grant_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
